// File: rtl/aes_key_expansion_ctrl.sv
// AES-128 key expansion sequencer: streams w[0..43] one word per
// valid/ready transfer, using a shared external 32-bit S-box.
// Ports: clk, rstN (async low); start/keyIn launch an expansion;
//   busy/done status; wordValid/wordReady/wordIndex/wordOut stream;
//   sboxIn/sboxOut drive the shared S-box.
// Option AES_KEYEXP_STORE_EN: 44-word store read by rdAddr -> rdKey.
module aes_key_expansion_ctrl (
  input  logic         clk,
  input  logic         rstN,
  input  logic         start,
  input  logic [127:0] keyIn,
  output logic         busy,
  output logic         wordValid,
  input  logic         wordReady,
  output logic [5:0]   wordIndex,
  output logic [31:0]  wordOut,
  output logic         done,
  output logic [31:0]  sboxIn,
  input  logic [31:0]  sboxOut
`ifdef AES_KEYEXP_STORE_EN
  ,
  input  logic [3:0]   rdAddr,
  output logic [127:0] rdKey
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    FINISH
  } state_t;

  state_t state, state_nxt;

  // win[0] is the oldest word w[i-4], win[3] the newest w[i-1]
  logic [3:0][31:0] win, win_nxt;
  logic [5:0]       idx, idx_nxt;
  logic [7:0]       rcon, rcon_nxt;

  logic        xfer;
  logic [31:0] temp;
  logic [31:0] word;

  assign busy      = (state == LOAD) || (state == EXPAND);
  assign wordValid = busy;
  assign done      = (state == FINISH);
  assign wordIndex = idx;
  assign sboxIn    = {win[3][23:0], win[3][31:24]};
  assign xfer      = wordValid && wordReady;

  always_comb begin
    temp = win[3];
    if (idx[1:0] == 2'd0)
      temp = sboxOut ^ {rcon, 24'h0};
  end

  always_comb begin
    word = '0;
    unique case (1'b1)
      state == LOAD:   word = win[idx[1:0]];
      state == EXPAND: word = win[0] ^ temp;
      default:         word = '0;
    endcase
  end

  assign wordOut = word;

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    idx_nxt   = idx;
    rcon_nxt  = rcon;
    unique case (state)
      IDLE: begin
        if (start) begin
          win_nxt   = {keyIn[31:0], keyIn[63:32],
                       keyIn[95:64], keyIn[127:96]};
          idx_nxt   = 6'd0;
          rcon_nxt  = 8'h01;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          idx_nxt = idx + 6'd1;
          if (idx == 6'd3)
            state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (xfer) begin
          win_nxt = {word, win[3], win[2], win[1]};
          idx_nxt = idx + 6'd1;
          if (idx[1:0] == 2'd0)
            rcon_nxt = {rcon[6:0], 1'b0}
                     ^ (rcon[7] ? 8'h1b : 8'h00);
          if (idx == 6'd43) begin
            idx_nxt   = 6'd0;
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      win   <= '0;
      idx   <= 6'd0;
      rcon  <= 8'h01;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      idx   <= idx_nxt;
      rcon  <= rcon_nxt;
    end
  end

`ifdef AES_KEYEXP_STORE_EN
  logic [31:0] store [44];
  logic [5:0]  base;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < 44; k++)
        store[k] <= '0;
    end else if (xfer) begin
      store[idx] <= word;
    end
  end

  assign base = {rdAddr, 2'b00};

  always_comb begin
    rdKey = '0;
    if (rdAddr <= 4'd10)
      rdKey = {store[base], store[base + 6'd1],
               store[base + 6'd2], store[base + 6'd3]};
  end
`endif

endmodule

// File: tb/tb_aes_key_expansion_ctrl.sv
// Bench for aes_key_expansion_ctrl: S-box and key schedule model,
// random stalls/start spam, reset abort, known-answer checks.
module tb_aes_key_expansion_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         word_valid;
  logic         word_ready;
  logic [5:0]   word_index;
  logic [31:0]  word_out;
  logic         done;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
`ifdef AES_KEYEXP_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
`endif

  logic [7:0]  sbox_tab [256];
  logic [31:0] ref_w [44];
  logic [31:0] got_w [44];
  logic [7:0]  rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expansion_ctrl dut (
    .clk       (clk),
    .rstN      (rst_n),
    .start     (start),
    .keyIn     (key_in),
    .busy      (busy),
    .wordValid (word_valid),
    .wordReady (word_ready),
    .wordIndex (word_index),
    .wordOut   (word_out),
    .done      (done),
    .sboxIn    (sbox_in),
    .sboxOut   (sbox_out)
`ifdef AES_KEYEXP_STORE_EN
    ,
    .rdAddr    (rd_addr),
    .rdKey     (rd_key)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign sbox_out = {sbox_tab[sbox_in[31:24]], sbox_tab[sbox_in[23:16]],
                     sbox_tab[sbox_in[15:8]], sbox_tab[sbox_in[7:0]]};

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 0;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_tab[x[31:24]], sbox_tab[x[23:16]],
            sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    for (int k = 0; k < 4; k++)
      ref_w[k] = key[127 - 32*k -: 32];
    for (int k = 4; k < 44; k++) begin
      logic [31:0] t = ref_w[k-1];
      if (k % 4 == 0)
        t = sub_word(rot_word(t)) ^ {rcon_tab[k/4], 24'h0};
      ref_w[k] = ref_w[k-4] ^ t;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_valid"}, word_valid, 0);
    check({tag, "_index"}, word_index, 0);
    check({tag, "_word"},  word_out,   0);
    check({tag, "_done"},  done,       0);
    check({tag, "_sbox"},  sbox_in,    0);
`ifdef AES_KEYEXP_STORE_EN
    check({tag, "_rdkey"}, rd_key,     0);
`endif
  endtask

  task automatic run(input logic [127:0] key, input bit stall,
                     input bit spam, input int abort_at);
    int cyc;
    int idx;
    bit seen_done;
    expand(key);
    @(negedge clk);
    key_in     = key;
    start      = 1;
    word_ready = 1;
    @(negedge clk);
    start     = 0;
    key_in    = ~key;
    cyc       = 1;
    idx       = 0;
    seen_done = 0;
    while (!seen_done && cyc < 2000) begin
      if (abort_at >= 0 && idx == abort_at && word_valid) begin
        #2 rst_n = 0;
        #1 check_reset_outputs("abort");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        rst_n = 1;
        return;
      end
      if (done) begin
        seen_done = 1;
        check("done_index", idx, 44);
        check("done_valid", word_valid, 0);
        check("done_busy", busy, 0);
        if (!stall) check("done_latency", cyc, 45);
      end else if (word_valid) begin
        check("busy", busy, 1);
        check("index", word_index, idx);
        check("word", word_out, ref_w[idx]);
        check("sbox_in", sbox_in, rot_word(ref_w[idx < 4 ? 3 : idx-1]));
      end else begin
        check("valid_gap", word_valid, 1);
      end
      word_ready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      if (spam) start = 1'($urandom_range(1, 0));
      if (word_valid && word_ready) begin
        got_w[idx] = word_out;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (!seen_done) check("timeout", 0, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
`ifdef AES_KEYEXP_STORE_EN
    for (int r = 0; r < 11; r++) begin
      rd_addr = 4'(r);
      #1 check("store_rd", rd_key,
               {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
    end
    rd_addr = 4'd11;
    #1 check("store_rd_oob", rd_key, 0);
    rd_addr = 4'd0;
`endif
  endtask

  initial begin
    rst_n      = 0;
    start      = 0;
    key_in     = '0;
    word_ready = 0;
`ifdef AES_KEYEXP_STORE_EN
    rd_addr    = 4'd0;
`endif
    build_sbox();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;

    run(FIPS_KEY, 0, 0, -1);
    check("fips_w0",  got_w[0],  32'h2b7e1516);
    check("fips_w4",  got_w[4],  32'ha0fafe17);
    check("fips_w43", got_w[43], 32'hb6630ca6);

    run(128'h0, 0, 0, -1);
    check("zero_w4", got_w[4], 32'h62636363);
    check("zero_round10", {got_w[40], got_w[41], got_w[42], got_w[43]},
          128'hb4ef5bcb3e92e21123e951cf6f8f188e);
`ifdef AES_KEYEXP_STORE_EN
    rd_addr = 4'd10;
    #1 check("zero_store10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
`endif

    run(FIPS_KEY, 1, 0, -1);
    check("stall_w43", got_w[43], 32'hb6630ca6);

    run(FIPS_KEY, 0, 1, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 0, 0, -1);

    run(FIPS_KEY, 1, 0, 20);
    run(FIPS_KEY, 0, 0, -1);
    check("post_abort_w43", got_w[43], 32'hb6630ca6);

    for (int k = 0; k < 3; k++)
      run({$urandom, $urandom, $urandom, $urandom}, 1, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
